// File: rtl/heat_zone_ctrl_pkg.sv
// Shared encodings and defaults for the multi-zone heating/cooling controller.
// Temperatures are signed fixed point with TEMP_FRAC fractional bits (1/16 degC).
package heat_zone_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HEAT  = 2'd1;
  localparam logic [1:0] ST_COOL  = 2'd2;
  localparam logic [1:0] ST_FAULT = 2'd3;

  localparam logic [1:0] MODE_OFF       = 2'b00;
  localparam logic [1:0] MODE_HEAT_ONLY = 2'b01;
  localparam logic [1:0] MODE_COOL_ONLY = 2'b10;
  localparam logic [1:0] MODE_AUTO      = 2'b11;

  localparam int TEMP_FRAC = 4;

  typedef struct packed {
    logic heat;
    logic cool;
    logic fault;
  } zone_out_t;

endpackage

// File: rtl/heat_zone_fsm.sv
// One zone: hysteresis compare, dwell counter and IDLE/HEAT/COOL/FAULT state.
// Outputs are registered; an input sampled at edge k is reflected after edge k.
module heat_zone_fsm
  import heat_zone_ctrl_pkg::*;
#(
  parameter int TEMP_W    = 12,
  parameter int HYST      = 32,
  parameter int MIN_DWELL = 4,
  parameter int T_MIN     = -640,
  parameter int T_MAX     = 1600
) (
  input  logic              clock,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic [TEMP_W-1:0] target,
  input  logic [TEMP_W-1:0] temp,
  output zone_out_t         zout
);

  localparam int DW = $clog2(MIN_DWELL + 1);
  localparam logic [DW-1:0] DWELL_MAX = DW'(MIN_DWELL);
  localparam logic signed [TEMP_W:0] HYST_X = (TEMP_W+1)'(HYST);
  localparam logic signed [TEMP_W:0] TMIN_X = (TEMP_W+1)'(T_MIN);
  localparam logic signed [TEMP_W:0] TMAX_X = (TEMP_W+1)'(T_MAX);

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  zone_out_t     out_q, out_d;

  logic signed [TEMP_W:0] temp_x, target_x, lo_x, hi_x;
  logic ready, heat_en, cool_en, out_of_range;

  always_comb begin
    // One extra bit keeps target +/- HYST from wrapping near the range limits.
    temp_x       = {temp[TEMP_W-1], temp};
    target_x     = {target[TEMP_W-1], target};
    lo_x         = target_x - HYST_X;
    hi_x         = target_x + HYST_X;
    ready        = (dwell_q == DWELL_MAX);
    heat_en      = (mode == MODE_HEAT_ONLY) || (mode == MODE_AUTO);
    cool_en      = (mode == MODE_COOL_ONLY) || (mode == MODE_AUTO);
    out_of_range = (temp_x < TMIN_X) || (temp_x > TMAX_X);

    state_d = state_q;
    if (out_of_range) begin
      state_d = ST_FAULT;
    end else if (state_q == ST_FAULT) begin
      if (mode == MODE_OFF) state_d = ST_IDLE;
    end else if (mode == MODE_OFF) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ready && (temp_x < lo_x) && heat_en) state_d = ST_HEAT;
          else if (ready && (temp_x > hi_x) && cool_en) state_d = ST_COOL;
        end
        ST_HEAT: begin
          if (ready && ((temp_x >= target_x) || (mode == MODE_COOL_ONLY))) state_d = ST_IDLE;
        end
        ST_COOL: begin
          if (ready && ((temp_x <= target_x) || (mode == MODE_HEAT_ONLY))) state_d = ST_IDLE;
        end
        default: state_d = state_q;
      endcase
    end

    if (state_d != state_q) dwell_d = '0;
    else if (!ready)        dwell_d = dwell_q + DW'(1);
    else                    dwell_d = dwell_q;

    out_d.heat  = (state_d == ST_HEAT);
    out_d.cool  = (state_d == ST_COOL);
    out_d.fault = (state_d == ST_FAULT);
  end

  // Dwell is preset on reset so a fresh start may drive on the first cycle.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= ST_IDLE;
      dwell_q <= DWELL_MAX;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      out_q   <= out_d;
    end
  end

  assign zout = out_q;

endmodule

// File: rtl/heat_zone_ctrl.sv
// Multi-zone heating/cooling controller: one heat_zone_fsm per zone plus summary lamps.
// Per-zone outputs are registered inside each zone; lamps are ORs of those flops.
module heat_zone_ctrl
  import heat_zone_ctrl_pkg::*;
#(
  parameter int N_ZONES   = 4,
  parameter int TEMP_W    = 12,
  parameter int HYST      = 32,
  parameter int MIN_DWELL = 4,
  parameter int T_MIN     = -640,
  parameter int T_MAX     = 1600
) (
  input  logic                      clock,
  input  logic                      rst,
  input  logic [2*N_ZONES-1:0]      zone_mode,
  input  logic [TEMP_W*N_ZONES-1:0] zone_target,
  input  logic [TEMP_W*N_ZONES-1:0] zone_temp,
  output logic [N_ZONES-1:0]        heat_on,
  output logic [N_ZONES-1:0]        cool_on,
  output logic [N_ZONES-1:0]        zone_fault,
  output logic                      led_red,
  output logic                      led_green,
  output logic                      fault_any
);

  zone_out_t zout [N_ZONES];

  for (genvar i = 0; i < N_ZONES; i++) begin : g_zone
    heat_zone_fsm #(
      .TEMP_W    (TEMP_W),
      .HYST      (HYST),
      .MIN_DWELL (MIN_DWELL),
      .T_MIN     (T_MIN),
      .T_MAX     (T_MAX)
    ) u_fsm (
      .clock  (clock),
      .rst    (rst),
      .mode   (zone_mode[2*i +: 2]),
      .target (zone_target[TEMP_W*i +: TEMP_W]),
      .temp   (zone_temp[TEMP_W*i +: TEMP_W]),
      .zout   (zout[i])
    );

    assign heat_on[i]    = zout[i].heat;
    assign cool_on[i]    = zout[i].cool;
    assign zone_fault[i] = zout[i].fault;
  end

  assign led_red   = |heat_on;
  assign led_green = |cool_on;
  assign fault_any = |zone_fault;

endmodule
